// File: rtl/alu_exec_sequencer_if.sv
// Bundle of controller, register-load and ALU-side signals for the execute sequencer.
// The slave modport belongs to the sequencer; the master modport belongs to the controller/ALU side.
interface alu_exec_sequencer_if #(
    parameter int unsigned W = 16
) ();
    logic         start;
    logic [2:0]   rd;
    logic [2:0]   rn;
    logic [2:0]   rm;
    logic [1:0]   shift;
    logic [1:0]   aluop_in;
    logic         wb_en;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [2:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic [1:0]   ALUop;
    logic [W-1:0] alu_to_C;
    logic [2:0]   alu_to_status;
    logic [W-1:0] C;
    logic [2:0]   status;
    logic         busy;
    logic         done;

    modport slave (
        input  start, rd, rn, rm, shift, aluop_in, wb_en,
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  alu_to_C, alu_to_status,
        output rd_data, Ain, Bin, ALUop, C, status, busy, done
    );

    modport master (
        output start, rd, rn, rm, shift, aluop_in, wb_en,
        output wr_en, wr_addr, wr_data, rd_addr,
        output alu_to_C, alu_to_status,
        input  rd_data, Ain, Bin, ALUop, C, status, busy, done
    );
endinterface

// File: rtl/alu_exec_sequencer.sv
// Multicycle operand-fetch / write-back stage around an external combinational 16-bit ALU.
// Owns the register file, operand latches, B-path shifter and result/status capture.
module alu_exec_sequencer #(
    parameter int unsigned NREG = 8,
    parameter int unsigned W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_exec_sequencer_if.slave  bus
);
    localparam int unsigned AW = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0]  regs [NREG];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rn_q;
    logic [AW-1:0] rm_q;
    logic [1:0]    shift_q;
    logic [1:0]    op_q;
    logic          wb_q;
    logic [W-1:0]  ain_q;
    logic [W-1:0]  bin_q;
    logic [W-1:0]  c_q;
    logic [1:0]    aluop_q;
    logic [2:0]    status_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  b_src;
    logic [W-1:0]  b_shifted;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: only IDLE waits, everything after it is a fixed walk
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD_A;
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they line up with the state itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == WB);
        end
    end

    // B-path shifter; the shifted-out bit is discarded
    always_comb begin
        b_src     = regs[rm_q];
        b_shifted = b_src;
        case (shift_q)
            2'b01:   b_shifted = {b_src[W-2:0], 1'b0};
            2'b10:   b_shifted = {1'b0, b_src[W-1:1]};
            2'b11:   b_shifted = {b_src[W-1], b_src[W-1:1]};
            default: b_shifted = b_src;
        endcase
    end

    // Instruction latch, register file, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
            rd_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            shift_q  <= '0;
            op_q     <= '0;
            wb_q     <= 1'b0;
            ain_q    <= '0;
            bin_q    <= '0;
            aluop_q  <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rd_q    <= bus.rd;
                        rn_q    <= bus.rn;
                        rm_q    <= bus.rm;
                        shift_q <= bus.shift;
                        op_q    <= bus.aluop_in;
                        wb_q    <= bus.wb_en;
                    end
                    if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
                end
                LOAD_A: ain_q <= regs[rn_q];
                LOAD_B: begin
                    bin_q   <= b_shifted;
                    aluop_q <= op_q;
                end
                EXEC: begin
                    c_q      <= bus.alu_to_C;
                    status_q <= bus.alu_to_status;
                end
                WB: if (wb_q) regs[rd_q] <= c_q;
                default: ;
            endcase
        end
    end

    assign bus.rd_data = regs[bus.rd_addr];
    assign bus.Ain     = ain_q;
    assign bus.Bin     = bin_q;
    assign bus.ALUop   = aluop_q;
    assign bus.C       = c_q;
    assign bus.status  = status_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
